// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, pixel colour type and the colour-bar palette.
package vga_pkg;

   localparam int unsigned DefHActive = 640;
   localparam int unsigned DefHFront  = 16;
   localparam int unsigned DefHSync   = 96;
   localparam int unsigned DefHBack   = 48;
   localparam int unsigned DefVActive = 480;
   localparam int unsigned DefVFront  = 10;
   localparam int unsigned DefVSync   = 2;
   localparam int unsigned DefVBack   = 33;
   localparam int unsigned DefClkDiv  = 2;
   localparam int unsigned DefCw      = 11;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

   localparam int unsigned NumBars = 8;

   // Left-to-right bar order: white, yellow, cyan, green, magenta, red, blue, black.
   localparam rgb_t ColourBars [NumBars] = '{
      '{8'hFF, 8'hFF, 8'hFF},
      '{8'hFF, 8'hFF, 8'h00},
      '{8'h00, 8'hFF, 8'hFF},
      '{8'h00, 8'hFF, 8'h00},
      '{8'hFF, 8'h00, 8'hFF},
      '{8'hFF, 8'h00, 8'h00},
      '{8'h00, 8'h00, 8'hFF},
      '{8'h00, 8'h00, 8'h00}
   };

endpackage

// File: rtl/vga_pixel_tick.sv
// Pixel-rate divider: produces a one-clock tick per pixel and a registered 50% duty vgaclock.
module vga_pixel_tick #(
   parameter int unsigned CLK_DIV = 2
) (
   input  logic clock_50,
   input  logic reset,
   input  logic enable,
   output logic tick,
   output logic vgaclock
);

   localparam int unsigned DW = $clog2(CLK_DIV);
   localparam logic [DW-1:0] DivLast = DW'(CLK_DIV - 1);
   localparam logic [DW-1:0] DivHalf = DW'(CLK_DIV / 2);

   logic [DW-1:0] div_q, div_d;
   logic          vgaclock_q, vgaclock_d;

   always_comb begin
      tick       = enable && (div_q == DivLast);
      div_d      = div_q;
      if (enable) begin
         div_d = tick ? '0 : div_q + DW'(1);
      end
      // Decoded from the next divider value so vgaclock lines up with the count it describes.
      vgaclock_d = (div_d >= DivHalf);
   end

   always_ff @(posedge clock_50 or posedge reset) begin
      if (reset) begin
         div_q      <= '0;
         vgaclock_q <= 1'b0;
      end else begin
         div_q      <= div_d;
         vgaclock_q <= vgaclock_d;
      end
   end

   assign vgaclock = vgaclock_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with registered, skew-free sync/blank/strobe outputs.
// Define VGA_TEST_PATTERN_EN to add red_out/green_out/blue_out colour-bar outputs.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int unsigned H_ACTIVE = DefHActive,
   parameter int unsigned H_FRONT  = DefHFront,
   parameter int unsigned H_SYNC   = DefHSync,
   parameter int unsigned H_BACK   = DefHBack,
   parameter int unsigned V_ACTIVE = DefVActive,
   parameter int unsigned V_FRONT  = DefVFront,
   parameter int unsigned V_SYNC   = DefVSync,
   parameter int unsigned V_BACK   = DefVBack,
   parameter logic        H_POL    = 1'b0,
   parameter logic        V_POL    = 1'b0,
   parameter int unsigned CLK_DIV  = DefClkDiv,
   parameter int unsigned CW       = DefCw
) (
   input  logic          clock_50,
   input  logic          reset,
   input  logic          enable,
   output logic          vgaclock,
   output logic          hsync,
   output logic          vsync,
   output logic          n_blank,
   output logic [CW-1:0] x,
   output logic [CW-1:0] y,
   output logic          line_start,
   output logic          frame_start
`ifdef VGA_TEST_PATTERN_EN
   ,
   output logic [7:0]    red_out,
   output logic [7:0]    green_out,
   output logic [7:0]    blue_out
`endif
);

   localparam int unsigned HTotal = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned VTotal = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [CW-1:0] HLast      = CW'(HTotal - 1);
   localparam logic [CW-1:0] VLast      = CW'(VTotal - 1);
   localparam logic [CW-1:0] HActive    = CW'(H_ACTIVE);
   localparam logic [CW-1:0] VActive    = CW'(V_ACTIVE);
   localparam logic [CW-1:0] HSyncStart = CW'(H_ACTIVE + H_FRONT);
   localparam logic [CW-1:0] HSyncEnd   = CW'(H_ACTIVE + H_FRONT + H_SYNC);
   localparam logic [CW-1:0] VSyncStart = CW'(V_ACTIVE + V_FRONT);
   localparam logic [CW-1:0] VSyncEnd   = CW'(V_ACTIVE + V_FRONT + V_SYNC);

   logic          tick;
   logic [CW-1:0] x_q, x_d, y_q, y_d;
   logic          hsync_q, hsync_d, vsync_q, vsync_d, n_blank_q, n_blank_d;
   logic          line_start_q, line_start_d, frame_start_q, frame_start_d;

   vga_pixel_tick #(
      .CLK_DIV (CLK_DIV)
   ) u_pixel_tick (
      .clock_50 (clock_50),
      .reset    (reset),
      .enable   (enable),
      .tick     (tick),
      .vgaclock (vgaclock)
   );

   // Outputs decode the next-state counters so they register on the same edge as x/y.
   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (tick) begin
         if (x_q == HLast) begin
            x_d = '0;
            y_d = (y_q == VLast) ? '0 : y_q + CW'(1);
         end else begin
            x_d = x_q + CW'(1);
         end
      end
      hsync_d       = ((x_d >= HSyncStart) && (x_d < HSyncEnd)) ? H_POL : ~H_POL;
      vsync_d       = ((y_d >= VSyncStart) && (y_d < VSyncEnd)) ? V_POL : ~V_POL;
      n_blank_d     = (x_d < HActive) && (y_d < VActive);
      line_start_d  = tick && (x_d == '0);
      frame_start_d = line_start_d && (y_d == '0);
   end

   always_ff @(posedge clock_50 or posedge reset) begin
      if (reset) begin
         x_q           <= HLast;
         y_q           <= VLast;
         hsync_q       <= ~H_POL;
         vsync_q       <= ~V_POL;
         n_blank_q     <= 1'b0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         x_q           <= x_d;
         y_q           <= y_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         n_blank_q     <= n_blank_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign x           = x_q;
   assign y           = y_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign n_blank     = n_blank_q;
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;

`ifdef VGA_TEST_PATTERN_EN
   localparam int unsigned BarW = H_ACTIVE / NumBars;

   logic [2:0] bar_idx;
   rgb_t       rgb_q, rgb_d;

   always_comb begin
      bar_idx = 3'(x_d / CW'(BarW));
      rgb_d   = n_blank_d ? ColourBars[bar_idx] : '0;
   end

   always_ff @(posedge clock_50 or posedge reset) begin
      if (reset) begin
         rgb_q <= '0;
      end else begin
         rgb_q <= rgb_d;
      end
   end

   assign red_out   = rgb_q.r;
   assign green_out = rgb_q.g;
   assign blue_out  = rgb_q.b;
`endif

endmodule
